// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter
// Lets two read requesters share one synchronous word ROM. One read is in
// flight at a time. Ties are resolved round-robin. The returned word goes back
// to the requester that won the grant, together with a one-cycle valid pulse.
module rom_read_arbiter #(
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 16,
   parameter int ROM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   // requester 0
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   // requester 1
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   // ROM side
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   // Wait counter only needs to reach ROM_LAT-1; keep at least one bit.
   localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   state_e            state_q;
   logic              rom_en_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic              owner_q;      // requester whose read is in flight
   logic              last_gnt_q;   // requester granted most recently
   logic [CNT_W-1:0]  cnt_q;
   logic              rvalid0_q;
   logic              rvalid1_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;

   logic              win0_d;
   logic              win1_d;
   logic              gnt0_d;
   logic              gnt1_d;

   // Round-robin pick: a lone request wins; on a tie the requester that was
   // not granted last time wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      win0_d = 1'b0;
      win1_d = 1'b0;
      gnt0_d = 1'b0;
      gnt1_d = 1'b0;
      if (req0 && req1) begin
         win0_d = last_gnt_q;
         win1_d = ~last_gnt_q;
      end else begin
         win0_d = req0;
         win1_d = req1;
      end
      if (state_q == S_IDLE) begin
         gnt0_d = win0_d;
         gnt1_d = win1_d;
      end
   end

   // Sequencer: grant in IDLE, strobe the ROM in ISSUE, count down the ROM
   // latency in WAIT, then return the word to the owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rom_en_q   <= 1'b0;
         rom_addr_q <= '0;
         owner_q    <= 1'b0;
         last_gnt_q <= 1'b1;
         cnt_q      <= '0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments, so every register sees the pre-edge values of the others.
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               rom_en_q <= 1'b0;
               if (gnt0_d) begin
                  rom_addr_q <= {addr0[ADDR_W-1:1], 1'b0};
                  rom_en_q   <= 1'b1;
                  owner_q    <= 1'b0;
                  last_gnt_q <= 1'b0;
                  state_q    <= S_ISSUE;
               end else if (gnt1_d) begin
                  rom_addr_q <= {addr1[ADDR_W-1:1], 1'b0};
                  rom_en_q   <= 1'b1;
                  owner_q    <= 1'b1;
                  last_gnt_q <= 1'b1;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               rom_en_q <= 1'b0;
               cnt_q    <= CNT_LOAD;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  if (owner_q) begin
                     rdata1_q  <= rom_data;
                     rvalid1_q <= 1'b1;
                  end else begin
                     rdata0_q  <= rom_data;
                     rvalid0_q <= 1'b1;
                  end
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               rom_en_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt0     = gnt0_d;
   assign gnt1     = gnt1_d;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign rom_en   = rom_en_q;
   assign rom_addr = rom_addr_q;

   // Structural invariants of the arbiter.
   a_gnt_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
      !(gnt0 && gnt1));
   a_en_only_issue : assert property (@(posedge clk) disable iff (!rst_n)
      rom_en |-> (state_q == S_ISSUE));
   a_addr_even     : assert property (@(posedge clk) disable iff (!rst_n)
      rom_addr[0] == 1'b0);

endmodule
